// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between the memory stage and a
// word-addressed data memory port.
// Optional feature: define MEM_TIMEOUT_EN to bound the wait for mem_ack to
// TIMEOUT cycles and report a bus error on expiry.

// Per-byte-lane store steering: byte enable and replicated store byte.
module mem_access_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  // Select enable and source byte for this lane from size/offset
  always_comb begin
    be    = 1'b0;
    wbyte = wdata[8*LANE +: 8];
    case (size)
      2'b00: begin
        be    = (off == 2'(LANE));
        wbyte = wdata[7:0];
      end
      2'b01: begin
        be    = (off == 2'(LANE & 2)) && !off[0];
        wbyte = wdata[8*(LANE % 2) +: 8];
      end
      2'b10: be = 1'b1;
      default: be = 1'b0;
    endcase
  end
endmodule

module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ec_din,
  output logic [2:0]        ec_cs,
  output logic              ec_sign,
  input  logic [31:0]       ec_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sign;
    logic [1:0] off;
  } req_t;

  state_t          state, state_d;
  req_t            req_q;
  logic            err_q;
  logic            accept;
  logic            bad;
  logic            tmo;
  logic [3:0]      be_c;
  logic [3:0][7:0] wd_c;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Illegal size or misaligned half/word never reaches the memory
  assign bad = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Store lane steering, one instance per byte lane
  for (genvar l = 0; l < 4; l++) begin : g_lane
    mem_access_lane #(.LANE(l)) u_lane (
      .size  (req_size),
      .off   (req_addr[1:0]),
      .wdata (req_wdata),
      .be    (be_c[l]),
      .wbyte (wd_c[l])
    );
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Limit hit on the edge the counter would reach TIMEOUT; an ack wins
  assign tmo = (state == ACCESS) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Count ACCESS cycles without ack; cleared on every accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          wait_cnt <= '0;
    else if (accept)                  wait_cnt <= '0;
    else if (state == ACCESS && !mem_ack) wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = bad ? RESP : ACCESS;
      ACCESS:  if (mem_ack || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, memory handshake, load steering and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      ec_din    <= '0;
      ec_cs     <= '0;
      ec_sign   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          req_q <= '{we: req_we, size: req_size, sign: req_sign, off: req_addr[1:0]};
          err_q <= bad;
          if (!bad) begin
            mem_en    <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= wd_c;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= '0;
            err_q  <= 1'b0;
            if (!req_q.we) begin
              ec_din  <= mem_rdata >> {req_q.off, 3'b000};
              ec_cs   <= (req_q.size == 2'b00) ? 3'b010 :
                         (req_q.size == 2'b01) ? 3'b001 : 3'b000;
              ec_sign <= (req_q.size != 2'b10) && req_q.sign;
            end
          end else if (tmo) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= '0;
            err_q  <= 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = (rsp_valid && !rsp_err && !req_q.we) ? ec_dout : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed table-driven bench for mem_access_ctrl with a behavioural
// extend/cut unit attached to ec_*.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;
  logic [31:0] ec_din, ec_dout;
  logic [2:0]  ec_cs;
  logic        ec_sign;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ec_din(ec_din), .ec_cs(ec_cs), .ec_sign(ec_sign), .ec_dout(ec_dout)
  );

  // External extend/cut unit model
  always_comb begin
    ec_dout = ec_din;
    case (ec_cs)
      3'b010: ec_dout = ec_sign ? {{24{ec_din[7]}}, ec_din[7:0]} : {24'h0, ec_din[7:0]};
      3'b001: ec_dout = ec_sign ? {{16{ec_din[15]}}, ec_din[15:0]} : {16'h0, ec_din[15:0]};
      default: ec_dout = ec_din;
    endcase
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          w;       // wait cycles before ack (ack sampled at accept+1+w)
    logic        err;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] ec_din;  // ec_* hold the last load's values otherwise
    logic [2:0]  cs;
    logic        es;
    logic [31:0] rexp;
    int          lat;     // edges from accept to rsp_valid
    int          en_cyc;  // cycles mem_en is high
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic start_req(input vec_t v);
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_sign  = v.sign;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    mem_rdata = v.rdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    int   c = 0, lat = -1, en_cyc = 0, bad_stable = 0;
    logic got_en = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic        r_err;
    logic [31:0] r_rdata, r_din;
    logic [2:0]  r_cs;
    logic        r_es;
    chk($sformatf("v%0d_ready", i), {31'h0, req_ready}, 32'h1);
    start_req(v);
    while (lat < 0 && c < 60) begin
      if (rsp_valid) begin
        lat = c; r_err = rsp_err; r_rdata = rsp_rdata;
        r_din = ec_din; r_cs = ec_cs; r_es = ec_sign;
      end
      if (mem_en) begin
        en_cyc++;
        if (!got_en) begin
          got_en = 1'b1;
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be; cap_we = mem_we;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                     mem_be !== cap_be || mem_we !== cap_we) begin
          bad_stable++;
        end
        if (req_ready) bad_stable++;
      end
      mem_ack = (c == v.w);
      if (lat < 0) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    mem_ack = 1'b0;
    chk($sformatf("v%0d_lat", i), lat, v.lat);
    chk($sformatf("v%0d_en_cycles", i), en_cyc, v.en_cyc);
    chk($sformatf("v%0d_stable", i), bad_stable, 0);
    if (lat >= 0) begin
      chk($sformatf("v%0d_err", i), {31'h0, r_err}, {31'h0, v.err});
      chk($sformatf("v%0d_rdata", i), r_rdata, v.rexp);
      chk($sformatf("v%0d_ec_din", i), r_din, v.ec_din);
      chk($sformatf("v%0d_ec_cs_sign", i), {28'h0, r_cs, r_es}, {28'h0, v.cs, v.es});
    end
    if (got_en) begin
      chk($sformatf("v%0d_be", i), {28'h0, cap_be}, {28'h0, v.be});
      chk($sformatf("v%0d_maddr", i), cap_addr, v.maddr);
      chk($sformatf("v%0d_we", i), {31'h0, cap_we}, {31'h0, v.we});
      if (v.we) chk($sformatf("v%0d_mwdata", i), cap_wdata, v.mwdata);
    end
  endtask

  initial begin
    //               we size sign addr          wdata          rdata         w  err be      maddr         mwdata        ec_din        cs      es rexp          lat en
    vecs.push_back('{0, 2'd0, 1, 32'h0000_0003, 32'h0,         32'h80FF_1234, 0, 0, 4'b1000, 32'h0,        32'h0,        32'h0000_0080, 3'b010, 1, 32'hFFFF_FF80, 2, 1});
    vecs.push_back('{0, 2'd1, 0, 32'h0000_0012, 32'h0,         32'h8001_0000, 3, 0, 4'b1100, 32'h10,       32'h0,        32'h0000_8001, 3'b001, 0, 32'h0000_8001, 5, 4});
    vecs.push_back('{1, 2'd0, 0, 32'h0000_0021, 32'h0000_00AB, 32'h0,         0, 0, 4'b0010, 32'h20,       32'hABAB_ABAB, 32'h0000_8001, 3'b001, 0, 32'h0,         2, 1});
    vecs.push_back('{0, 2'd2, 0, 32'h0000_0006, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,        32'h0,        32'h0000_8001, 3'b001, 0, 32'h0,         1, 0});
    vecs.push_back('{0, 2'd3, 0, 32'h0000_0000, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,        32'h0,        32'h0000_8001, 3'b001, 0, 32'h0,         1, 0});
    vecs.push_back('{0, 2'd2, 1, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1, 0, 4'b1111, 32'h40,       32'h0,        32'hDEAD_BEEF, 3'b000, 0, 32'hDEAD_BEEF, 3, 2});
    vecs.push_back('{1, 2'd1, 0, 32'h0000_001A, 32'h1234_5678, 32'h0,         0, 0, 4'b1100, 32'h18,       32'h5678_5678, 32'hDEAD_BEEF, 3'b000, 0, 32'h0,         2, 1});
    vecs.push_back('{0, 2'd1, 1, 32'h0000_0002, 32'h0,         32'hFFFE_0000, 2, 0, 4'b1100, 32'h0,        32'h0,        32'h0000_FFFE, 3'b001, 1, 32'hFFFF_FFFE, 4, 3});
    vecs.push_back('{1, 2'd1, 0, 32'h0000_0003, 32'h1,         32'h0,         0, 1, 4'b0000, 32'h0,        32'h0,        32'h0000_FFFE, 3'b001, 1, 32'h0,         1, 0});
    vecs.push_back('{0, 2'd0, 0, 32'h0000_0001, 32'h0,         32'h0000_9A00, 0, 0, 4'b0010, 32'h0,        32'h0,        32'h0000_009A, 3'b010, 0, 32'h0000_009A, 2, 1});
    vecs.push_back('{1, 2'd2, 0, 32'h0000_0044, 32'hCAFE_F00D, 32'h0,         0, 0, 4'b1111, 32'h44,       32'hCAFE_F00D, 32'h0000_009A, 3'b010, 0, 32'h0,         2, 1});
    // ack on the 15th ACCESS cycle: normal completion in either build
    vecs.push_back('{0, 2'd2, 0, 32'h0000_0080, 32'h0,         32'h1122_3344, 14, 0, 4'b1111, 32'h80,      32'h0,        32'h1122_3344, 3'b000, 0, 32'h1122_3344, 16, 15});
`ifdef MEM_TIMEOUT_EN
    // no ack at all: bus error after 15 cycles of mem_en
    vecs.push_back('{0, 2'd2, 0, 32'h0000_0084, 32'h0,         32'h0,         99, 1, 4'b1111, 32'h84,      32'h0,        32'h1122_3344, 3'b000, 0, 32'h0,         16, 15});
`else
    // no timeout: a long wait still completes normally
    vecs.push_back('{0, 2'd2, 0, 32'h0000_0084, 32'h0,         32'h55AA_55AA, 20, 0, 4'b1111, 32'h84,      32'h0,        32'h55AA_55AA, 3'b000, 0, 32'h55AA_55AA, 22, 21});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_outs", {28'h0, mem_en, rsp_valid, rsp_err, mem_we}, 32'h0);
    chk("rst_be_cs", {25'h0, mem_be, ec_cs}, 32'h0);
    chk("rst_ec_din", ec_din, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // Reset during ACCESS: abandon the access, then a fresh one completes
    start_req(vecs[1]);
    chk("mid_en_before", {31'h0, mem_en}, 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {29'h0, mem_en, rsp_valid, req_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("mid_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    run_vec(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
